// File: rtl/rf_arb_pkg.sv
// Shared constants and FSM state type for the register-file access arbiter.
package rf_arb_pkg;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rf_access_arbiter_if.sv
// Requester-side and register-file-side signals of the arbiter, bundled.
interface rf_access_arbiter_if import rf_arb_pkg::*; ();
  // rd_req/wr_req are held by the requester until the matching *_gnt is high in
  // the same cycle; a granted read returns rd_rdata with rd_rvalid one cycle later.
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] rf_a;
  logic [DW-1:0] rf_d;
  logic          rf_wen;
  logic [DW-1:0] rf_q;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, clr_start, rf_q,
    output rd_gnt, rd_rvalid, rd_rdata, wr_gnt, clr_busy, clr_done,
           rf_a, rf_d, rf_wen
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, clr_start, rf_q,
    input  rd_gnt, rd_rvalid, rd_rdata, wr_gnt, clr_busy, clr_done,
           rf_a, rf_d, rf_wen
  );
endinterface

// File: rtl/rf_clear_seq.sv
// Clear-sweep sequencer: walks every address once, then pulses done.
module rf_clear_seq import rf_arb_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output arb_state_e    state,
  output logic [AW-1:0] cnt,
  output logic          busy,
  output logic          done
);
  arb_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        // Last address is written this cycle; done lands on the first idle cycle.
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;
  assign cnt   = cnt_q;
  assign busy  = (state_q == CLEAR);
  assign done  = done_q;
endmodule

// File: rtl/rf_access_arbiter.sv
// Single-port register-file arbiter: fetch reads vs loader writes, plus clear sweep.
module rf_access_arbiter import rf_arb_pkg::*; #(
  parameter int WR_BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  rf_access_arbiter_if.slave bus,
  output arb_state_e         dbg_state
);
  localparam int SW = $clog2(WR_BURST_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(WR_BURST_MAX);

  arb_state_e    state;
  logic [AW-1:0] clr_cnt;
  logic          clr_busy;
  logic          clr_done;
  logic          clr_go;
  logic          arb_en;
  logic          rd_gnt;
  logic          wr_gnt;
  logic [SW-1:0] streak_q, streak_d;
  logic          rvalid_q, rvalid_d;
  logic [AW-1:0] rf_a;
  logic [DW-1:0] rf_d;
  logic          rf_wen;

  // A starting sweep steals its launch cycle too, so requests stall there.
  assign clr_go = (state == IDLE) && bus.clr_start;
  assign arb_en = (state == IDLE) && !bus.clr_start && !rst;

  rf_clear_seq u_clear_seq (
    .clk   (clk),
    .rst   (rst),
    .start (clr_go),
    .state (state),
    .cnt   (clr_cnt),
    .busy  (clr_busy),
    .done  (clr_done)
  );

  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (arb_en) begin
      if (bus.wr_req && (!bus.rd_req || streak_q != STREAK_MAX)) begin
        wr_gnt = 1'b1;
      end else if (bus.rd_req) begin
        rd_gnt = 1'b1;
      end
    end
  end

  // Streak counts writes that overtook a waiting read; it bounds read starvation.
  always_comb begin
    streak_d = streak_q;
    if (rd_gnt || !bus.rd_req) begin
      streak_d = '0;
    end else if (wr_gnt && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_comb begin
    rvalid_d = rd_gnt;
    rf_a     = bus.rd_addr;
    rf_d     = bus.wr_data;
    rf_wen   = 1'b1;
    if (clr_busy) begin
      rf_a   = clr_cnt;
      rf_d   = '0;
      rf_wen = 1'b0;
    end else if (wr_gnt) begin
      rf_a   = bus.wr_addr;
      rf_d   = bus.wr_data;
      rf_wen = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rd_gnt    = rd_gnt;
  assign bus.wr_gnt    = wr_gnt;
  assign bus.rd_rvalid = rvalid_q;
  assign bus.rd_rdata  = bus.rf_q;
  assign bus.clr_busy  = clr_busy;
  assign bus.clr_done  = clr_done;
  assign bus.rf_a      = rf_a;
  assign bus.rf_d      = rf_d;
  assign bus.rf_wen    = rf_wen;
  assign dbg_state     = state;
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a register-file model and read scoreboard.
module tb_rf_access_arbiter;
  import rf_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_access_arbiter_if bus ();
  arb_state_e dbg_state;

  rf_access_arbiter #(.WR_BURST_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Register-file model: synchronous write, registered read of the old content.
  logic [DW-1:0] rf_mem [DEPTH];
  always @(posedge clk) begin
    if (!bus.rf_wen) rf_mem[bus.rf_a] <= bus.rf_d;
    bus.rf_q <= rf_mem[bus.rf_a];
  end

  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic          pend = 1'b0;
  int            cmp_cnt  = 0;
  int            fail_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected read data is queued at grant, checked one cycle later.
  always @(negedge clk) begin
    chk("rvalid_timing", bus.rd_rvalid, pend);
    if (bus.rd_rvalid) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        fail_cnt++;
        $error("FAIL sb_underflow: observed=rvalid expected=no_read_pending");
      end else begin
        chk("rd_rdata", bus.rd_rdata, exp_q.pop_front());
      end
    end
    pend = bus.rd_gnt;
    if (bus.rd_gnt) exp_q.push_back(shadow[bus.rd_addr]);
    if (bus.wr_gnt) shadow[bus.wr_addr] = bus.wr_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    chk("wr_gnt", bus.wr_gnt, 1'b1);
    chk("wr_rf_wen", bus.rf_wen, 1'b0);
    chk("wr_rf_a", bus.rf_a, a);
    chk("wr_rf_d", bus.rf_d, d);
    step();
    bus.wr_req = 1'b0;
  endtask

  task automatic rd_op(input logic [AW-1:0] a);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    @(negedge clk);
    chk("rd_gnt", bus.rd_gnt, 1'b1);
    chk("rd_rf_wen", bus.rf_wen, 1'b1);
    chk("rd_rf_a", bus.rf_a, a);
    step();
    bus.rd_req = 1'b0;
  endtask

  task automatic arb_cyc(input logic r, input logic w, input logic er, input logic ew);
    bus.rd_req  = r;
    bus.wr_req  = w;
    bus.wr_addr = AW'($urandom_range(0, DEPTH - 1));
    bus.wr_data = $urandom;
    @(negedge clk);
    chk("arb_rd_gnt", bus.rd_gnt, er);
    chk("arb_wr_gnt", bus.wr_gnt, ew);
    step();
    if (er) bus.rd_addr = AW'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic fill_all(input logic [DW-1:0] d);
    for (int i = 0; i < DEPTH; i++) wr_op(AW'(i), d);
  endtask

  initial begin
    // Reset with both requests raised: nothing may be granted.
    rst           = 1'b1;
    bus.rd_req    = 1'b1;
    bus.wr_req    = 1'b1;
    bus.rd_addr   = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_start = 1'b0;
    @(negedge clk);
    chk("rst_rd_gnt", bus.rd_gnt, 1'b0);
    chk("rst_wr_gnt", bus.wr_gnt, 1'b0);
    chk("rst_rf_wen", bus.rf_wen, 1'b1);
    chk("rst_clr_busy", bus.clr_busy, 1'b0);
    chk("rst_rvalid", bus.rd_rvalid, 1'b0);
    step();
    rst        = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_clr_done", bus.clr_done, 1'b0);
    step();

    // Preload with random data, entry 5 holding a known pattern.
    for (int i = 0; i < DEPTH; i++) wr_op(AW'(i), (i == 5) ? 32'hDEADBEEF : $urandom);

    // Read only.
    rd_op(7'd5);
    @(negedge clk);
    chk("read5_rvalid", bus.rd_rvalid, 1'b1);
    chk("read5_rdata", bus.rd_rdata, 32'hDEADBEEF);
    step();

    // Write then read the same address back to back.
    wr_op(7'h7F, 32'h12345678);
    rd_op(7'h7F);
    @(negedge clk);
    chk("wr_rd_rdata", bus.rd_rdata, 32'h12345678);
    chk("wr_rd_rf_wen_after", bus.rf_wen, 1'b1);
    step();

    // Full contention for 20 cycles: W,W,W,W,R repeating.
    bus.rd_addr = AW'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 20; i++) arb_cyc(1'b1, 1'b1, (i % 5) == 4, (i % 5) != 4);

    // A cycle with rd_req low clears the streak.
    arb_cyc(1'b1, 1'b1, 1'b0, 1'b1);
    arb_cyc(1'b1, 1'b1, 1'b0, 1'b1);
    arb_cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) arb_cyc(1'b1, 1'b1, i == 4, i != 4);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;

    // Clear sweep with requests pending and a stray clr_start mid-sweep.
    fill_all(32'hFFFFFFFF);
    bus.rd_req    = 1'b1;
    bus.rd_addr   = 7'd64;
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 7'd3;
    bus.wr_data   = 32'hAAAA5555;
    bus.clr_start = 1'b1;
    @(negedge clk);
    chk("clr_launch_rd_gnt", bus.rd_gnt, 1'b0);
    chk("clr_launch_wr_gnt", bus.wr_gnt, 1'b0);
    chk("clr_launch_rf_wen", bus.rf_wen, 1'b1);
    chk("clr_launch_busy", bus.clr_busy, 1'b0);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      bus.clr_start = (k == 10);
      @(negedge clk);
      chk("clr_busy", bus.clr_busy, 1'b1);
      chk("clr_rf_a", bus.rf_a, k[AW-1:0]);
      chk("clr_rf_wen", bus.rf_wen, 1'b0);
      chk("clr_rf_d", bus.rf_d, 32'h0);
      chk("clr_rd_gnt", bus.rd_gnt, 1'b0);
      chk("clr_wr_gnt", bus.wr_gnt, 1'b0);
      chk("clr_done_early", bus.clr_done, 1'b0);
      step();
    end
    bus.clr_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    @(negedge clk);
    chk("clr_end_busy", bus.clr_busy, 1'b0);
    chk("clr_done", bus.clr_done, 1'b1);
    chk("clr_end_state", dbg_state, IDLE);
    chk("post_clr_wr_first", bus.wr_gnt, 1'b1);
    chk("post_clr_rd_wait", bus.rd_gnt, 1'b0);
    step();
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("clr_done_pulse", bus.clr_done, 1'b0);
    chk("post_clr_rd_gnt", bus.rd_gnt, 1'b1);
    step();
    bus.rd_req = 1'b0;
    rd_op(7'd0);
    rd_op(7'd127);
    rd_op(7'd3);
    @(negedge clk);
    step();

    // Reset in the middle of a sweep, while clearing address 60.
    fill_all(32'hFFFFFFFF);
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    repeat (60) step();
    rst = 1'b1;
    #1;
    chk("midclr_busy", bus.clr_busy, 1'b0);
    chk("midclr_done", bus.clr_done, 1'b0);
    chk("midclr_rf_wen", bus.rf_wen, 1'b1);
    chk("midclr_state", dbg_state, IDLE);
    for (int i = 0; i < 60; i++) shadow[i] = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midclr_no_done", bus.clr_done, 1'b0);
    step();
    rd_op(7'd0);
    rd_op(7'd59);
    rd_op(7'd61);
    rd_op(7'd127);
    @(negedge clk);
    step();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Controller for the 128x32 instruction register file: shares its single port between an instruction-fetch read requester and a loader write requester, and sequences a full-array clear sweep on command. It drives the register file's address, data and active-low write-enable pins and returns read data with valid tagging. It sits between the fetch/load logic and the register file instance.

## Interface

- AW, 7, register-file address width (depth 2^AW = 128)
- DW, 32, data width
- WR_BURST_MAX, 4, max consecutive write grants while a read is pending (≥1)

- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- rd_req  in  1  fetch read request, held until granted
- rd_addr  in  AW  read address
- rd_gnt  out  1  read granted this cycle (combinational)
- rd_rvalid  out  1  read data valid (registered)
- rd_rdata  out  DW  read data, meaningful only when rd_rvalid
- wr_req  in  1  loader write request, held until granted
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_gnt  out  1  write granted this cycle (combinational)
- clr_start  in  1  single-cycle pulse: begin clear sweep
- clr_busy  out  1  clear sweep in progress (registered)
- clr_done  out  1  one-cycle pulse after last clear write
- rf_a  out  AW  register-file address
- rf_d  out  DW  register-file write data
- rf_wen  out  1  register-file write enable, active low
- rf_q  in  DW  register-file registered read data

## Operation

- States: IDLE, CLEAR. Reset -> IDLE.
- IDLE, clr_start=1: -> CLEAR, clr_cnt=0; no grants that cycle. Requests pending at the same time are stalled.
- CLEAR: rf_a=clr_cnt, rf_d=0, rf_wen=0, rd_gnt=wr_gnt=0. clr_cnt increments each cycle. On clr_cnt=127: write, then -> IDLE, clr_done=1 for the next cycle. clr_start during CLEAR is ignored.
- IDLE arbitration:
  - only rd_req: rd_gnt=1.
  - only wr_req: wr_gnt=1.
  - both: write wins unless streak==WR_BURST_MAX; then read wins.
- streak counter (0..WR_BURST_MAX):
  - +1 on a cycle with wr_gnt and rd_req=1.
  - cleared on rd_gnt, or when rd_req=0.
  - saturating.
- Port muxing:
  - wr_gnt: rf_a=wr_addr, rf_d=wr_data, rf_wen=0.
  - rd_gnt or no access: rf_a=rd_addr, rf_d=wr_data, rf_wen=1.
- Read return: rd_rvalid <= rd_gnt; rd_rdata = rf_q (pass-through).
- Reset values: rd_rvalid=0, clr_busy=0, clr_done=0, streak=0, clr_cnt=0. rd_gnt=wr_gnt=0 and rf_wen=1 while rst=1.
- Reset mid-CLEAR: immediate -> IDLE; no clr_done. The array is left partially cleared.

## Timing

- Grants are combinational from request and state; no extra request-to-grant latency.
- Read latency: rd_gnt at cycle t -> rd_rvalid/rd_rdata at t+1. Data is the array content at edge t.
- Write at t, then read of the same address at t+1: returns the new data.
- Sustained read throughput: 1 per cycle. Under full contention, reads get 1 slot per WR_BURST_MAX+1 cycles.
- Clear sweep: exactly 128 cycles with clr_busy=1, then a clr_done pulse with clr_busy=0.

## Structure

- Package rf_arb_pkg: AW, DW, DEPTH=2**AW, state enum {IDLE, CLEAR}.
- One sub-module: rf_clear_seq (clr_cnt, busy/done generation). The arbiter top holds the streak counter, grant logic, port mux and rvalid register.

## Test plan

- Read only: rd_req, rd_addr=5, with array[5]=0xDEADBEEF -> rd_gnt same cycle; next cycle rd_rvalid=1, rd_rdata=0xDEADBEEF.
- Write then read: wr 0x12345678 @ 0x7F, then rd @ 0x7F the next cycle -> rd_rdata=0x12345678. rf_wen=0 only in the write cycle.
- Contention: rd_req and wr_req held high for 20 cycles, WR_BURST_MAX=4 -> grant pattern W,W,W,W,R repeating. rd_rvalid follows each R by one cycle.
- Clear: fill all entries with 0xFFFFFFFF, pulse clr_start -> clr_busy for 128 cycles, no grants, single clr_done. Subsequent reads of 0, 64 and 127 return 0.
- Reset mid-clear: assert rst at clr_cnt=60 -> clr_busy=0 immediately, no clr_done. Entries 0..59 read 0 and 61..127 read 0xFFFFFFFF; entry 60 reads either value.
- clr_start during CLEAR and with requests pending -> the sweep stays 128 cycles. Pending rd/wr are granted in the first IDLE cycle after the sweep, write first.
